// File: rtl/irq_timer_if.sv
// Register bus between a CPU-side master and the irq_timer slave.
// The master drives the word select, write strobe and write data. The timer
// returns combinational read data and a level-sensitive interrupt request.
interface irq_timer_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  modport master (
    output addr,
    output we,
    output wd,
    input  rd,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  wd,
    output rd,
    output irq
  );
endinterface

// File: rtl/irq_timer.sv
// Programmable down-counting interrupt timer.
// Register map:
//   word 0 = CTRL   (bit 0 EN, bits 2:1 MODE, bit 3 IM)
//   word 1 = PRESET
//   word 2 = COUNT  (read-only)
//   word 3 = reserved, reads as zero
// MODE 01 reloads the counter from PRESET after every interrupt.
// Every other MODE value behaves as one-shot, and one-shot clears EN once the
// interrupt fires. A CPU write to CTRL or PRESET always returns the sequencer
// to IDLE and drops a pending interrupt. That write overrides whatever the
// sequencer would otherwise have done on the same edge.
module irq_timer (
  input  logic        clk,
  input  logic        reset,
  irq_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irqf_q, irqf_d;

  logic        wrCtrl;
  logic        wrPreset;
  logic        cpuWrite;
  logic        enable;
  logic        reloadMode;
  logic        countExpiring;

  // Decode the CPU write strobes and control fields.
  // A COUNT of 0 or 1 both mean "expire this edge", so that PRESET=0 acts like PRESET=1.
  always_comb begin
    wrCtrl        = bus.we && (bus.addr == ADDR_CTRL);
    wrPreset      = bus.we && (bus.addr == ADDR_PRESET);
    cpuWrite      = wrCtrl || wrPreset;
    enable        = ctrl_q[0];
    reloadMode    = (ctrl_q[2:1] == MODE_RELOAD);
    countExpiring = (count_q <= 32'd1);
  end

  // State register plus the programmer-visible registers; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      irqf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irqf_q   <= irqf_d;
    end
  end

  // Next-state logic; any CTRL/PRESET write forces the sequencer back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = CNT;
      end
      CNT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (countExpiring) begin
          state_d = INT;
        end
      end
      INT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (cpuWrite) begin
      state_d = IDLE;
    end
  end

  // Register updates per state; CPU writes are applied last so they win over the sequencer.
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    irqf_d   = irqf_q;
    case (state_q)
      LOAD: begin
        count_d = preset_q;
      end
      CNT: begin
        if (enable) begin
          if (countExpiring) begin
            count_d = 32'd0;
            irqf_d  = 1'b1;
          end else begin
            count_d = count_q - 32'd1;
          end
        end
      end
      INT: begin
        if (reloadMode) begin
          irqf_d = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
        end
      end
      default: begin
      end
    endcase
    if (wrCtrl) begin
      ctrl_d = bus.wd[3:0];
      irqf_d = 1'b0;
    end
    if (wrPreset) begin
      preset_d = bus.wd;
      irqf_d   = 1'b0;
    end
  end

  // Read mux and masked interrupt output, both purely combinational.
  always_comb begin
    case (bus.addr)
      ADDR_CTRL:   bus.rd = {28'd0, ctrl_q};
      ADDR_PRESET: bus.rd = preset_q;
      ADDR_COUNT:  bus.rd = count_q;
      default:     bus.rd = 32'd0;
    endcase
    bus.irq = irqf_q && ctrl_q[3];
  end

endmodule
